// File: rtl/reaction_round_if.sv
// Player/display bundle of the reaction-timer round controller.
// The bench or top level drives start and the stop buttons; the controller drives everything else.
interface reaction_round_if #(
    parameter int SCORE_W = 4
);
    logic               start;
    logic               p0_stop;
    logic               p1_stop;
    logic [1:0]         cnt_ctrl;
    logic               led;
    logic [1:0]         winner;
    logic [1:0]         foul;
    logic [SCORE_W-1:0] score0;
    logic [SCORE_W-1:0] score1;
    logic [3:0]         round_idx;
    logic               game_over;

    modport master (
        output start, p0_stop, p1_stop,
        input  cnt_ctrl, led, winner, foul, score0, score1, round_idx, game_over
    );

    modport slave (
        input  start, p0_stop, p1_stop,
        output cnt_ctrl, led, winner, foul, score0, score1, round_idx, game_over
    );
endinterface

// File: rtl/reaction_round_ctrl.sv
// Two-player multi-round reaction game sequencer: random foreperiod, go phase,
// first-press arbitration, foul and score tracking, final result hold.
module reaction_round_ctrl #(
    parameter int DLY_MIN       = 100_000_000,
    parameter int DLY_SPAN_LOG2 = 27,
    parameter int TIMEOUT       = 150_000_000,
    parameter int GAP           = 100_000_000,
    parameter int ROUNDS        = 5,
    parameter int SCORE_W       = 4
) (
    input  logic             clk_50M,
    input  logic             clear_n,
    reaction_round_if.slave  rr
);
    localparam int          CW         = 32;
    localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;
    localparam logic [1:0]  CNT_CLEAR  = 2'b00;
    localparam logic [1:0]  CNT_HOLD   = 2'b01;
    localparam logic [1:0]  CNT_RUN    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_GO     = 3'd2,
        S_RESULT = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [CW-1:0]      dly_q, dly_d;
    logic [CW-1:0]      go_q, go_d;
    logic [CW-1:0]      gap_q, gap_d;
    logic               start_dly_q, start_dly_d;
    logic               p0_dly_q, p0_dly_d;
    logic               p1_dly_q, p1_dly_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               led_q, led_d;
    logic [1:0]         winner_q, winner_d;
    logic [1:0]         foul_q, foul_d;
    logic [SCORE_W-1:0] score0_q, score0_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [3:0]         round_q, round_d;
    logic               game_over_q, game_over_d;

    logic               start_edge_s;
    logic               p0_edge_s;
    logic               p1_edge_s;
    logic [CW-1:0]      dly_load_s;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + SCORE_W'(1'b1);
        end
    endfunction

    assign start_edge_s = rr.start & ~start_dly_q;
    assign p0_edge_s    = rr.p0_stop & ~p0_dly_q;
    assign p1_edge_s    = rr.p1_stop & ~p1_dly_q;
    assign dly_load_s   = CW'(DLY_MIN) + CW'(lfsr_q[DLY_SPAN_LOG2-1:0]);

    // Next-state and next-output computation for the round sequencer.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0000_0000);
        dly_d       = dly_q;
        go_d        = go_q;
        gap_d       = gap_q;
        start_dly_d = rr.start;
        p0_dly_d    = rr.p0_stop;
        p1_dly_d    = rr.p1_stop;
        cnt_d       = cnt_q;
        led_d       = led_q;
        winner_d    = winner_q;
        foul_d      = foul_q;
        score0_d    = score0_q;
        score1_d    = score1_q;
        round_d     = round_q;
        game_over_d = game_over_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge_s) begin
                    state_d     = S_WAIT;
                    score0_d    = '0;
                    score1_d    = '0;
                    round_d     = 4'd0;
                    winner_d    = 2'b00;
                    foul_d      = 2'b00;
                    cnt_d       = CNT_CLEAR;
                    led_d       = 1'b0;
                    game_over_d = 1'b0;
                    dly_d       = dly_load_s;
                end else begin
                    state_d = state_q;
                end
            end
            S_WAIT: begin
                led_d = 1'b0;
                cnt_d = CNT_CLEAR;
                // A press on the expiry cycle is still a foul: presses are checked first.
                if (p0_edge_s || p1_edge_s) begin
                    state_d = S_RESULT;
                    cnt_d   = CNT_HOLD;
                    gap_d   = 32'd0;
                    foul_d  = {p1_edge_s, p0_edge_s};
                    if (p0_edge_s && p1_edge_s) begin
                        winner_d = 2'b11;
                    end else if (p0_edge_s) begin
                        winner_d = 2'b10;
                        score1_d = sat_inc(score1_q);
                    end else begin
                        winner_d = 2'b01;
                        score0_d = sat_inc(score0_q);
                    end
                end else if (dly_q == 32'd0) begin
                    state_d = S_GO;
                    led_d   = 1'b1;
                    cnt_d   = CNT_RUN;
                    go_d    = 32'd0;
                end else begin
                    dly_d = dly_q - 32'd1;
                end
            end
            S_GO: begin
                if (p0_edge_s || p1_edge_s) begin
                    state_d  = S_RESULT;
                    led_d    = 1'b0;
                    cnt_d    = CNT_HOLD;
                    gap_d    = 32'd0;
                    winner_d = {p1_edge_s, p0_edge_s};
                    if (p0_edge_s && p1_edge_s) begin
                        winner_d = 2'b11;
                    end else if (p0_edge_s) begin
                        score0_d = sat_inc(score0_q);
                    end else begin
                        score1_d = sat_inc(score1_q);
                    end
                end else if (go_q == CW'(TIMEOUT - 1)) begin
                    state_d  = S_RESULT;
                    led_d    = 1'b0;
                    cnt_d    = CNT_HOLD;
                    gap_d    = 32'd0;
                    winner_d = 2'b00;
                end else begin
                    go_d = go_q + 32'd1;
                end
            end
            S_RESULT: begin
                if (gap_q == CW'(GAP - 1)) begin
                    if (round_q == 4'(ROUNDS - 1)) begin
                        state_d     = S_DONE;
                        game_over_d = 1'b1;
                    end else begin
                        state_d  = S_WAIT;
                        round_d  = round_q + 4'd1;
                        winner_d = 2'b00;
                        foul_d   = 2'b00;
                        cnt_d    = CNT_CLEAR;
                        dly_d    = dly_load_s;
                    end
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, timers, edge history, LFSR and registered outputs.
    always_ff @(posedge clk_50M or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= 32'h0000_0001;
            dly_q       <= 32'd0;
            go_q        <= 32'd0;
            gap_q       <= 32'd0;
            start_dly_q <= 1'b0;
            p0_dly_q    <= 1'b0;
            p1_dly_q    <= 1'b0;
            cnt_q       <= CNT_CLEAR;
            led_q       <= 1'b0;
            winner_q    <= 2'b00;
            foul_q      <= 2'b00;
            score0_q    <= '0;
            score1_q    <= '0;
            round_q     <= 4'd0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            dly_q       <= dly_d;
            go_q        <= go_d;
            gap_q       <= gap_d;
            start_dly_q <= start_dly_d;
            p0_dly_q    <= p0_dly_d;
            p1_dly_q    <= p1_dly_d;
            cnt_q       <= cnt_d;
            led_q       <= led_d;
            winner_q    <= winner_d;
            foul_q      <= foul_d;
            score0_q    <= score0_d;
            score1_q    <= score1_d;
            round_q     <= round_d;
            game_over_q <= game_over_d;
        end
    end

    assign rr.cnt_ctrl  = cnt_q;
    assign rr.led       = led_q;
    assign rr.winner    = winner_q;
    assign rr.foul      = foul_q;
    assign rr.score0    = score0_q;
    assign rr.score1    = score1_q;
    assign rr.round_idx = round_q;
    assign rr.game_over = game_over_q;
endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl with short simulation timings.
module tb_reaction_round_ctrl;
    localparam int DLY_MIN = 20;
    localparam int SPAN    = 3;
    localparam int TIMEOUT = 50;
    localparam int GAP     = 10;
    localparam int ROUNDS  = 3;
    localparam int SCORE_W = 4;

    logic clk;
    logic clear_n;
    int   checks;
    int   errors;
    int   cyc;
    logic seen_run;

    reaction_round_if #(.SCORE_W(SCORE_W)) rr ();

    reaction_round_ctrl #(
        .DLY_MIN(DLY_MIN), .DLY_SPAN_LOG2(SPAN), .TIMEOUT(TIMEOUT),
        .GAP(GAP), .ROUNDS(ROUNDS), .SCORE_W(SCORE_W)
    ) dut (
        .clk_50M (clk),
        .clear_n (clear_n),
        .rr      (rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts clock edges until led rises; gives up after 60.
    task automatic wait_led(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rr.led !== 1'b1 && n < 60);
        chk("led_rise_seen", {31'd0, rr.led}, 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_n = 1'b0;
        rr.start = 1'b0;
        rr.p0_stop = 1'b0;
        rr.p1_stop = 1'b0;
        step(2);
        chk("rst_cnt", rr.cnt_ctrl, 32'd0);
        chk("rst_led", rr.led, 32'd0);
        chk("rst_winner", rr.winner, 32'd0);
        chk("rst_foul", rr.foul, 32'd0);
        chk("rst_score0", rr.score0, 32'd0);
        chk("rst_score1", rr.score1, 32'd0);
        chk("rst_round", rr.round_idx, 32'd0);
        chk("rst_game_over", rr.game_over, 32'd0);
        clear_n = 1'b1;
        step(2);

        // Game 1, round 0: start, then p1 wins 5 cycles after go.
        rr.start = 1'b1;
        step(1);
        rr.start = 1'b0;
        chk("wait_cnt", rr.cnt_ctrl, 32'd0);
        chk("wait_led", rr.led, 32'd0);
        wait_led(cyc);
        // Foreperiod of DLY_MIN+r counts (r in 0..7) plus the expiry cycle.
        chk("fore_len_in_range", {31'd0, (cyc >= DLY_MIN + 1) && (cyc <= DLY_MIN + 8)}, 32'd1);
        chk("go_cnt_run", rr.cnt_ctrl, 32'd2);
        step(4);
        rr.p1_stop = 1'b1;
        step(1);
        rr.p1_stop = 1'b0;
        chk("r0_led_off", rr.led, 32'd0);
        chk("r0_cnt_hold", rr.cnt_ctrl, 32'd1);
        chk("r0_winner", rr.winner, 32'd2);
        chk("r0_score1", rr.score1, 32'd1);
        chk("r0_score0", rr.score0, 32'd0);
        step(9);
        chk("r0_result_held_winner", rr.winner, 32'd2);
        chk("r0_result_held_cnt", rr.cnt_ctrl, 32'd1);
        step(1);
        chk("r1_round", rr.round_idx, 32'd1);
        chk("r1_winner_clr", rr.winner, 32'd0);
        chk("r1_cnt_clear", rr.cnt_ctrl, 32'd0);

        // Round 1: p0 fouls during the foreperiod.
        seen_run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (rr.cnt_ctrl === 2'b10) seen_run = 1'b1;
        end
        rr.p0_stop = 1'b1;
        step(1);
        rr.p0_stop = 1'b0;
        chk("r1_foul", rr.foul, 32'd1);
        chk("r1_winner", rr.winner, 32'd2);
        chk("r1_score1", rr.score1, 32'd2);
        chk("r1_score0", rr.score0, 32'd0);
        for (int i = 0; i < 9; i++) begin
            if (rr.cnt_ctrl === 2'b10) seen_run = 1'b1;
            step(1);
        end
        chk("r1_never_run", {31'd0, seen_run}, 32'd0);
        step(1);
        chk("r2_round", rr.round_idx, 32'd2);
        chk("r2_foul_clr", rr.foul, 32'd0);

        // Round 2: both press on the same cycle in GO.
        wait_led(cyc);
        rr.p0_stop = 1'b1;
        rr.p1_stop = 1'b1;
        step(1);
        rr.p0_stop = 1'b0;
        rr.p1_stop = 1'b0;
        chk("r2_tie_winner", rr.winner, 32'd3);
        chk("r2_tie_score0", rr.score0, 32'd0);
        chk("r2_tie_score1", rr.score1, 32'd2);
        chk("r2_tie_foul", rr.foul, 32'd0);
        step(9);
        chk("r2_not_done_yet", rr.game_over, 32'd0);
        step(1);
        chk("done_game_over", rr.game_over, 32'd1);
        chk("done_cnt", rr.cnt_ctrl, 32'd1);
        chk("done_winner", rr.winner, 32'd3);
        rr.p1_stop = 1'b1;
        step(2);
        rr.p1_stop = 1'b0;
        chk("done_press_ignored", rr.score1, 32'd2);
        chk("done_frozen_round", rr.round_idx, 32'd2);

        // Game 2: restart from DONE, both foul in the same cycle.
        rr.start = 1'b1;
        step(1);
        rr.start = 1'b0;
        chk("g2_score1_clr", rr.score1, 32'd0);
        chk("g2_round_clr", rr.round_idx, 32'd0);
        chk("g2_game_over_clr", rr.game_over, 32'd0);
        chk("g2_cnt_clear", rr.cnt_ctrl, 32'd0);
        step(3);
        rr.p0_stop = 1'b1;
        rr.p1_stop = 1'b1;
        step(1);
        rr.p0_stop = 1'b0;
        rr.p1_stop = 1'b0;
        chk("g2_both_foul", rr.foul, 32'd3);
        chk("g2_both_winner", rr.winner, 32'd3);
        chk("g2_both_score0", rr.score0, 32'd0);
        chk("g2_both_score1", rr.score1, 32'd0);
        step(10);
        chk("g2_r1_round", rr.round_idx, 32'd1);

        // Round 1: no press, go phase times out; a mid-round start is ignored.
        wait_led(cyc);
        rr.start = 1'b1;
        step(1);
        rr.start = 1'b0;
        step(48);
        chk("to_still_led", rr.led, 32'd1);
        chk("to_still_run", rr.cnt_ctrl, 32'd2);
        chk("to_start_ignored", rr.round_idx, 32'd1);
        step(1);
        chk("to_led_off", rr.led, 32'd0);
        chk("to_cnt_hold", rr.cnt_ctrl, 32'd1);
        chk("to_winner_void", rr.winner, 32'd0);
        step(10);
        chk("g2_r2_round", rr.round_idx, 32'd2);

        // Round 2: asynchronous clear in the middle of GO.
        wait_led(cyc);
        step(2);
        clear_n = 1'b0;
        #1;
        chk("clr_led", rr.led, 32'd0);
        chk("clr_cnt", rr.cnt_ctrl, 32'd0);
        chk("clr_round", rr.round_idx, 32'd0);
        chk("clr_winner", rr.winner, 32'd0);
        @(negedge clk);
        clear_n = 1'b1;
        step(1);
        rr.p0_stop = 1'b1;
        step(2);
        rr.p0_stop = 1'b0;
        chk("idle_press_foul", rr.foul, 32'd0);
        chk("idle_press_score1", rr.score1, 32'd0);
        chk("idle_press_cnt", rr.cnt_ctrl, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
